// File: rtl/rtc_bus_responder.sv
// RTC stand-in on the multiplexed 8-bit bus: BCD time/date bank advancing once per TICK_DIV clocks.
// Writes land 2 clk after Write rises; read data/ad_oe follow Read low by 1 clk; no backpressure (bus strobes only).
module rtc_bus_responder #(
  parameter int         TICK_DIV  = 100000000,
  parameter logic [7:0] ADDR_BASE = 8'h21,
  parameter logic [7:0] CTRL_ADDR = 8'h20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ChipSelect,
  input  logic       Read,
  input  logic       Write,
  input  logic       AoD,
  input  logic [7:0] ad_in,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  output logic       tick_1hz,
  output logic       halted
);
  localparam int            PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  logic            cs_q, rd_q, rd_qq, wr_q, wr_qq, aod_q, aod_qq;
  logic [7:0]      ad_q, ad_qq;
  logic [7:0]      addr, ctrl;
  logic [5:0][7:0] tm, tm_nxt, lo, hi;
  logic [PW-1:0]   presc;

  logic            wr_evt, rd_evt, wr_data, addr_lat, ctrl_we, tick, leap, rd_cond, carry;
  logic [7:0]      idx, rdata, day_max;
  logic [8:0]      step;
  logic [5:0]      bank_we;

  // Returns {carry, next}; anything invalid or at/after the field maximum restarts at the minimum.
  function automatic logic [8:0] bcd_step(input logic [7:0] v, input logic [7:0] v_lo,
                                          input logic [7:0] v_hi);
    if (v[3:0] > 4'd9 || v[7:4] > 4'd9 || v < v_lo || v >= v_hi) return {1'b1, v_lo};
    if (v[3:0] == 4'd9) return {1'b0, v[7:4] + 4'd1, 4'd0};
    return {1'b0, v + 8'd1};
  endfunction

  assign wr_evt   = wr_q & ~wr_qq & ~cs_q;
  assign rd_evt   = rd_q & ~rd_qq & ~cs_q & ~aod_qq;
  assign wr_data  = wr_evt & aod_qq;
  assign addr_lat = (wr_evt | rd_evt) & ~aod_qq;
  assign idx      = addr - ADDR_BASE;
  assign ctrl_we  = wr_data & (addr == CTRL_ADDR);
  assign tick     = ~ctrl[0] & (presc == PRESC_MAX);
  assign halted   = ctrl[0];
  assign rd_cond  = ~ChipSelect & ~Read & AoD & Write;

  always_comb begin
    bank_we = '0;
    rdata   = (addr == CTRL_ADDR) ? ctrl : 8'hFF;
    for (int i = 0; i < 6; i++) begin
      bank_we[i] = wr_data & (idx == 8'(i));
      if (idx == 8'(i)) rdata = tm[i];
    end
  end

  // BCD year divisible by 4: even tens with ones 0/4/8, odd tens with ones 2/6.
  always_comb begin
    leap = tm[5][4] ? (tm[5][3:0] == 4'd2 || tm[5][3:0] == 4'd6)
                    : (tm[5][3:0] == 4'd0 || tm[5][3:0] == 4'd4 || tm[5][3:0] == 4'd8);
    case (tm[4])
      8'h02:                      day_max = leap ? 8'h29 : 8'h28;
      8'h04, 8'h06, 8'h09, 8'h11: day_max = 8'h30;
      default:                    day_max = 8'h31;
    endcase
  end

  assign lo = {8'h00, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00};
  assign hi = {8'h99, 8'h12, day_max, 8'h23, 8'h59, 8'h59};

  // Ripple the tick through the fields; a write to a field overrides it and kills its carry.
  always_comb begin
    carry  = tick;
    step   = '0;
    tm_nxt = tm;
    for (int i = 0; i < 6; i++) begin
      step = bcd_step(tm[i], lo[i], hi[i]);
      if (carry) tm_nxt[i] = step[7:0];
      carry = carry & step[8];
      if (bank_we[i]) begin
        tm_nxt[i] = ad_qq;
        carry     = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cs_q     <= 1'b1;
      rd_q     <= 1'b1;
      rd_qq    <= 1'b1;
      wr_q     <= 1'b1;
      wr_qq    <= 1'b1;
      aod_q    <= 1'b0;
      aod_qq   <= 1'b0;
      ad_q     <= 8'h00;
      ad_qq    <= 8'h00;
      addr     <= 8'h00;
      ctrl     <= 8'h00;
      tm       <= {8'h00, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00};
      presc    <= '0;
      tick_1hz <= 1'b0;
      ad_oe    <= 1'b0;
      ad_out   <= 8'h00;
    end else begin
      cs_q     <= ChipSelect;
      rd_q     <= Read;
      rd_qq    <= rd_q;
      wr_q     <= Write;
      wr_qq    <= wr_q;
      aod_q    <= AoD;
      aod_qq   <= aod_q;
      ad_q     <= ad_in;
      ad_qq    <= ad_q;
      if (addr_lat) addr <= ad_qq;
      if (ctrl_we)  ctrl <= ad_qq;
      tm       <= tm_nxt;
      if (bank_we[0] || tick) presc <= '0;
      else if (!ctrl[0])      presc <= presc + PW'(1);
      tick_1hz <= tick;
      ad_oe    <= rd_cond;
      ad_out   <= rd_cond ? rdata : 8'h00;
    end
  end
endmodule

// File: tb/tb_rtc_bus_responder.sv
// Bench for rtc_bus_responder: directed bus transactions plus random time/date rollovers.
module tb_rtc_bus_responder;
  localparam int         TICK_DIV = 10;
  localparam logic [7:0] BASE     = 8'h21;
  localparam logic [7:0] CTRL     = 8'h20;

  typedef logic [5:0][7:0] tm_t;

  logic       clk = 1'b0;
  logic       reset, ChipSelect, Read, Write, AoD;
  logic [7:0] ad_in, ad_out;
  logic       ad_oe, tick_1hz, halted;
  int         errors = 0;
  int         checks = 0;

  rtc_bus_responder #(.TICK_DIV(TICK_DIV), .ADDR_BASE(BASE), .CTRL_ADDR(CTRL)) dut (
    .clk(clk), .reset(reset), .ChipSelect(ChipSelect), .Read(Read), .Write(Write),
    .AoD(AoD), .ad_in(ad_in), .ad_out(ad_out), .ad_oe(ad_oe), .tick_1hz(tick_1hz),
    .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int b2i(input logic [7:0] v);
    return int'(v[7:4]) * 10 + int'(v[3:0]);
  endfunction

  function automatic logic [7:0] i2b(input int n);
    logic [7:0] r;
    r[7:4] = 4'(n / 10);
    r[3:0] = 4'(n % 10);
    return r;
  endfunction

  function automatic tm_t mk(input logic [7:0] s, input logic [7:0] mi, input logic [7:0] h,
                             input logic [7:0] d, input logic [7:0] mo, input logic [7:0] y);
    return {y, mo, d, h, mi, s};
  endfunction

  // Calendar model: one second later, working on decimal integers.
  function automatic tm_t next_time(input tm_t f);
    tm_t r;
    int  lo[6];
    int  hi[6];
    int  v, m, y;
    bit  carry;
    r  = f;
    m  = b2i(f[4]);
    y  = b2i(f[5]);
    lo = '{0, 0, 0, 1, 1, 0};
    hi = '{59, 59, 23, 31, 12, 99};
    if (m == 2) hi[3] = (y % 4 == 0) ? 29 : 28;
    else if (m == 4 || m == 6 || m == 9 || m == 11) hi[3] = 30;
    carry = 1'b1;
    for (int i = 0; i < 6 && carry; i++) begin
      v = b2i(f[i]);
      if (f[i][3:0] > 4'd9 || f[i][7:4] > 4'd9 || v < lo[i] || v >= hi[i]) r[i] = i2b(lo[i]);
      else begin
        r[i]  = i2b(v + 1);
        carry = 1'b0;
      end
    end
    return r;
  endfunction

  function automatic int pick(input int max);
    if ($urandom_range(0, 1) == 1) return max;
    return int'($urandom_range(0, max));
  endfunction

  // All bus tasks are entered and left just after a falling clock edge.
  task automatic bus_wr(input logic aod, input logic [7:0] v);
    ChipSelect = 1'b0; AoD = aod; ad_in = v; Write = 1'b0;
    @(negedge clk); Write = 1'b1;
    @(negedge clk);
    @(negedge clk); ChipSelect = 1'b1;
  endtask

  task automatic reg_wr(input logic [7:0] a, input logic [7:0] v);
    bus_wr(1'b0, a);
    bus_wr(1'b1, v);
  endtask

  task automatic reg_rd(input logic [7:0] a, input logic [7:0] exp, input string tag);
    bus_wr(1'b0, a);
    ChipSelect = 1'b0; AoD = 1'b1; Read = 1'b0;
    @(posedge clk); #1;
    check({tag, ".oe"}, ad_oe, 1);
    check(tag, ad_out, exp);
    @(negedge clk); Read = 1'b1; ChipSelect = 1'b1;
    @(posedge clk); #1;
    check({tag, ".oe_drop"}, ad_oe, 0);
    @(negedge clk);
  endtask

  task automatic wait_tick(input int limit, output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!tick_1hz && n < limit);
  endtask

  // Load a time while halted, let exactly one second pass, halt again and read back.
  task automatic run_case(input tm_t din, input tm_t dexp, input string tag);
    int n;
    for (int i = 5; i >= 0; i--) reg_wr(BASE + 8'(i), din[i]);
    reg_wr(CTRL, 8'h00);
    wait_tick(3 * TICK_DIV, n);
    check({tag, ".tick_cycles"}, n, TICK_DIV);
    @(negedge clk);
    reg_wr(CTRL, 8'h01);
    for (int i = 0; i < 6; i++) reg_rd(BASE + 8'(i), dexp[i], $sformatf("%s.f%0d", tag, i));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tm_t rst_tm, din;
    int  n, ticks;
    rst_tm = mk(8'h00, 8'h00, 8'h00, 8'h01, 8'h01, 8'h00);
    reset = 1'b1; ChipSelect = 1'b1; Read = 1'b1; Write = 1'b1; AoD = 1'b0; ad_in = 8'h00;
    repeat (3) @(negedge clk);
    check("rst.ad_oe", ad_oe, 0);
    check("rst.ad_out", ad_out, 8'h00);
    check("rst.tick", tick_1hz, 0);
    check("rst.halted", halted, 0);
    reset = 1'b0;

    reg_wr(CTRL, 8'h01);
    check("halt.flag", halted, 1);
    check("idle.ad_oe", ad_oe, 0);
    for (int i = 0; i < 6; i++) reg_rd(BASE + 8'(i), rst_tm[i], $sformatf("rst.f%0d", i));
    reg_rd(CTRL, 8'h01, "ctrl.rd");

    reg_wr(8'h22, 8'h45);
    reg_rd(8'h22, 8'h45, "min.wr");
    reg_wr(CTRL, 8'hA5);
    check("ctrl.a5.halted", halted, 1);
    reg_rd(CTRL, 8'hA5, "ctrl.a5");
    reg_wr(CTRL, 8'h01);
    reg_wr(8'h30, 8'h77);
    reg_rd(8'h30, 8'hFF, "unmapped.30");
    reg_rd(8'h27, 8'hFF, "unmapped.27");
    reg_rd(8'h22, 8'h45, "unmapped.no_effect");

    run_case(mk(8'h59, 8'h59, 8'h23, 8'h28, 8'h02, 8'h23),
             mk(8'h00, 8'h00, 8'h00, 8'h01, 8'h03, 8'h23), "feb23");
    run_case(mk(8'h59, 8'h59, 8'h23, 8'h28, 8'h02, 8'h24),
             mk(8'h00, 8'h00, 8'h00, 8'h29, 8'h02, 8'h24), "feb24");
    run_case(mk(8'h59, 8'h59, 8'h23, 8'h31, 8'h12, 8'h99),
             mk(8'h00, 8'h00, 8'h00, 8'h01, 8'h01, 8'h00), "nye99");
    run_case(mk(8'h7A, 8'h10, 8'h05, 8'h15, 8'h06, 8'h20),
             mk(8'h00, 8'h11, 8'h05, 8'h15, 8'h06, 8'h20), "badsec");
    run_case(mk(8'h59, 8'h59, 8'h23, 8'h31, 8'h04, 8'h20),
             mk(8'h00, 8'h00, 8'h00, 8'h01, 8'h05, 8'h20), "apr31");
    for (int k = 0; k < 6; k++) begin
      din[0] = ($urandom_range(0, 5) == 0) ? 8'($urandom) : i2b(pick(59));
      din[1] = i2b(pick(59));
      din[2] = i2b(pick(23));
      din[3] = i2b(int'($urandom_range(1, 31)));
      din[4] = i2b(int'($urandom_range(1, 12)));
      din[5] = i2b(int'($urandom_range(0, 99)));
      run_case(din, next_time(din), $sformatf("rand%0d", k));
    end

    // Land a sec write on the very edge where sec would roll 59 -> 00.
    reg_wr(BASE + 8'd1, 8'h12);
    reg_wr(BASE, 8'h58);
    reg_wr(CTRL, 8'h00);
    wait_tick(3 * TICK_DIV, n);
    check("collide.first_tick", n, TICK_DIV);
    @(negedge clk);
    bus_wr(1'b0, BASE);
    repeat (4) @(negedge clk);
    bus_wr(1'b1, 8'h30);
    reg_wr(CTRL, 8'h01);
    reg_rd(BASE, 8'h30, "collide.sec");
    reg_rd(BASE + 8'd1, 8'h12, "collide.min");

    check("halt.flag2", halted, 1);
    ticks = 0;
    repeat (50) begin
      @(posedge clk); #1;
      if (tick_1hz) ticks++;
    end
    check("halt.no_tick", ticks, 0);
    @(negedge clk);
    reg_rd(BASE, 8'h30, "halt.sec_hold");
    reg_wr(CTRL, 8'h00);
    check("resume.halted", halted, 0);
    wait_tick(3 * TICK_DIV, n);
    check("resume.tick_seen", n <= TICK_DIV, 1);
    @(negedge clk);
    reg_wr(CTRL, 8'h01);
    reg_rd(BASE, 8'h31, "resume.sec");

    // Reset between address and data phase; Write rises while reset is high.
    bus_wr(1'b0, BASE);
    ChipSelect = 1'b0; AoD = 1'b1; ad_in = 8'h33; Write = 1'b0;
    @(negedge clk); reset = 1'b1;
    @(negedge clk); Write = 1'b1;
    @(negedge clk);
    check("rst2.halted", halted, 0);
    check("rst2.ad_oe", ad_oe, 0);
    check("rst2.tick", tick_1hz, 0);
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk); ChipSelect = 1'b1;
    reg_wr(CTRL, 8'h01);
    for (int i = 0; i < 6; i++) reg_rd(BASE + 8'(i), rst_tm[i], $sformatf("rst2.f%0d", i));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
